// File: rtl/multi_pad_controller.sv
// multi_pad_controller: polls NUM_PADS NES/SNES shift-register pads over one shared latch/pulse pair.
// Optional feature macro PAD_DEBOUNCE_EN: a pad field only updates when two consecutive raw frames agree.
module multi_pad_controller #(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BUTTONS = 8,
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_PADS-1:0]             data,
  output logic                            latch,
  output logic                            pulse,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic                            valid,
  output logic                            busy,
  output logic [2:0]                      state_dbg
);

  // Handshake: start is a request level, looked at only in IDLE (ignored while busy=1);
  // valid is a one-cycle strobe with no backpressure, and buttons is stable between strobes.

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(NUM_BUTTONS + 1);
  localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [BIT_W-1:0]         bit_idx;
  logic [TMR_W-1:0]         timer;
  logic                     pending;
  logic [NUM_BUTTONS-1:0]   shadow       [NUM_PADS];
  logic [NUM_BUTTONS-1:0]   shadow_shift [NUM_PADS];
`ifdef PAD_DEBOUNCE_EN
  logic [NUM_BUTTONS-1:0]   prev_raw     [NUM_PADS];
`endif

  logic wrap, latch_end, half_end, last_bit, go;

  assign wrap      = (timer == TMR_W'(POLL_PERIOD - 1));
  assign latch_end = (cnt == CNT_W'(2 * CLK_DIV - 1));
  assign half_end  = (cnt == CNT_W'(CLK_DIV - 1));
  assign last_bit  = (bit_idx == BIT_W'(NUM_BUTTONS - 1));
  // A wrap is honoured on the same IDLE cycle so start+wrap yields a single frame.
  assign go        = start | pending | wrap;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go)        state_nxt = S_LATCH;
      S_LATCH: if (latch_end) state_nxt = S_LOW;
      S_LOW:   if (half_end)  state_nxt = S_HIGH;
      S_HIGH:  if (half_end)  state_nxt = last_bit ? S_DONE : S_LOW;
      S_DONE:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Bits arrive LSB first; shifting right places the first bit at index 0 after NUM_BUTTONS shifts.
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++)
      shadow_shift[p] = NUM_BUTTONS'({~data[p], shadow[p]} >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      timer   <= '0;
      pending <= 1'b0;
      for (int p = 0; p < NUM_PADS; p++) shadow[p] <= '0;
    end else begin
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      timer <= wrap ? '0 : timer + 1'b1;
      if (state == S_IDLE && state_nxt == S_LATCH) pending <= 1'b0;
      else if (wrap)                               pending <= 1'b1;
      if (state == S_LATCH)
        bit_idx <= '0;
      else if (state == S_HIGH && half_end)
        bit_idx <= bit_idx + 1'b1;
      if (state == S_LOW && half_end)
        for (int p = 0; p < NUM_PADS; p++) shadow[p] <= shadow_shift[p];
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch   <= 1'b0;
      pulse   <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      buttons <= '0;
`ifdef PAD_DEBOUNCE_EN
      for (int p = 0; p < NUM_PADS; p++) prev_raw[p] <= '0;
`endif
    end else begin
      latch <= (state_nxt == S_LATCH);
      pulse <= (state_nxt == S_HIGH);
      valid <= (state_nxt == S_DONE);
      busy  <= (state_nxt != S_IDLE);
      if (state_nxt == S_DONE) begin
        for (int p = 0; p < NUM_PADS; p++) begin
`ifdef PAD_DEBOUNCE_EN
          if (shadow[p] == prev_raw[p])
            buttons[p*NUM_BUTTONS +: NUM_BUTTONS] <= shadow[p];
          prev_raw[p] <= shadow[p];
`else
          buttons[p*NUM_BUTTONS +: NUM_BUTTONS] <= shadow[p];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_pad_controller.sv
// Bench for multi_pad_controller: pad shift-register models, frame-level reference model, directed sequence.
module tb_multi_pad_controller;
  localparam int NP  = 2;
  localparam int NB  = 8;
  localparam int CD  = 2;
  localparam int PP  = 100;
  localparam int PPB = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    data;
  logic             latch, pulse, valid, busy;
  logic [NP*NB-1:0] buttons;
  logic [2:0]       state_dbg;

  logic [NP-1:0]    data_b = 2'b10;
  logic             latch_b, pulse_b, valid_b, busy_b;
  logic [NP*NB-1:0] buttons_b;
  logic [2:0]       state_dbg_b;

  multi_pad_controller #(.NUM_PADS(NP), .NUM_BUTTONS(NB), .CLK_DIV(CD), .POLL_PERIOD(PP)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .latch(latch), .pulse(pulse),
    .buttons(buttons), .valid(valid), .busy(busy), .state_dbg(state_dbg));

  multi_pad_controller #(.NUM_PADS(NP), .NUM_BUTTONS(NB), .CLK_DIV(CD), .POLL_PERIOD(PPB)) dut_b (
    .clk(clk), .rst(rst), .start(1'b0), .data(data_b), .latch(latch_b), .pulse(pulse_b),
    .buttons(buttons_b), .valid(valid_b), .busy(busy_b), .state_dbg(state_dbg_b));

  int checks = 0;
  int errors = 0;
  int cyc;

  // cycle label: an output seen after the k-th clock edge since reset release belongs to cycle k
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // pad models: load the pressed word on latch, shift on each pulse rising edge, output active-low
  logic [NB-1:0] pad_word [NP];
  logic [NB-1:0] sr       [NP];
  logic          pulse_q;
  always @(negedge clk) begin
    pulse_q <= pulse;
    for (int p = 0; p < NP; p++) begin
      if (rst && latch == 1'b0 && cyc == 0 && sr[p] === 'x) sr[p] <= '0;
      else if (latch)                                      sr[p] <= pad_word[p];
      else if (pulse && !pulse_q)                          sr[p] <= sr[p] >> 1;
    end
  end
  always_comb begin
    data = '1;
    for (int p = 0; p < NP; p++) data[p] = ~sr[p][0];
  end

  // monitors
  int   pulse_rises, latch_cycles, busy_low, valid_cnt;
  logic pulse_m = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pulse && !pulse_m) pulse_rises++;
      if (latch)  latch_cycles++;
      if (!busy)  busy_low++;
      if (valid)  valid_cnt++;
    end
    pulse_m = pulse;
  end

  int            vb_cyc [$];
  logic [15:0]   vb_btn [$];
  int            b_idle = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_b) begin
        vb_cyc.push_back(cyc);
        vb_btn.push_back(buttons_b);
      end
      if (!busy_b && cyc >= 21 && cyc <= 322) b_idle++;
    end
  end

  // reference model: a frame publishes each pad's pressed word (debounce: only if it repeats)
  logic [NB-1:0] exp_btn  [NP];
  logic [NB-1:0] prev_raw [NP];

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      exp_btn[p]  = '0;
      prev_raw[p] = '0;
    end
  endtask

  task automatic model_frame();
    for (int p = 0; p < NP; p++) begin
`ifdef PAD_DEBOUNCE_EN
      if (pad_word[p] == prev_raw[p]) exp_btn[p] = pad_word[p];
      prev_raw[p] = pad_word[p];
`else
      exp_btn[p] = pad_word[p];
`endif
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    pulse_rises  = 0;
    latch_cycles = 0;
    busy_low     = 0;
    valid_cnt    = 0;
  endtask

  task automatic wait_valid(output int c);
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (valid) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic frame_check(input int exp_cyc, input int exp_idle);
    int c;
    wait_valid(c);
    check("valid_cycle", c, exp_cyc);
    model_frame();
    for (int p = 0; p < NP; p++)
      check($sformatf("buttons_pad%0d", p), buttons[p*NB +: NB], exp_btn[p]);
    check("pulse_rises", pulse_rises, NB);
    check("latch_cycles", latch_cycles, 2 * CD);
    check("valid_count", valid_cnt, 1);
    if (exp_idle >= 0) check("idle_cycles", busy_low, exp_idle);
    clear_counts();
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_latch"}, latch, 0);
    check({tag, "_pulse"}, pulse, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_buttons"}, buttons, 0);
  endtask

  // release reset on a falling edge so the next rising edge is cycle 0
  task automatic release_reset(input logic start_now);
    @(negedge clk);
    rst   = 1'b0;
    start = start_now;
    model_reset();
    #1;
    clear_counts();
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      sr[p]       = '0;
      pad_word[p] = '0;
    end
    model_reset();
    clear_counts();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_outputs_check("por");

    // single start at cycle 0, then automatic polls every PP cycles with random pads
    pad_word[0] = 8'hA5;
    pad_word[1] = 8'h00;
    release_reset(1'b1);
    @(negedge clk);
    start = 1'b0;
    frame_check(37, 0);
    for (int f = 1; f < 4; f++) begin
      for (int p = 0; p < NP; p++) pad_word[p] = NB'($urandom_range(0, 255));
      frame_check(PP * f + 36, -1);
    end

    // short poll period: frames run back to back, one IDLE cycle between them
    check("b_frames", vb_cyc.size(), 8);
    for (int k = 0; k < 8 && k < vb_cyc.size(); k++) begin
      check($sformatf("b_valid_cycle%0d", k), vb_cyc[k], 56 + 38 * k);
`ifdef PAD_DEBOUNCE_EN
      check($sformatf("b_buttons%0d", k), vb_btn[k], (k == 0) ? 32'h0 : 32'h00FF);
`else
      check($sformatf("b_buttons%0d", k), vb_btn[k], 32'h00FF);
`endif
    end
    check("b_idle_cycles", b_idle, 7);

    // start held high across frames; pad0 sequence exercises debounce
    rst = 1'b1;
    #3;
    pad_word[0] = 8'h0F;
    pad_word[1] = NB'($urandom_range(0, 255));
    release_reset(1'b1);
    frame_check(37, 0);
    pad_word[1] = NB'($urandom_range(0, 255));
    frame_check(75, 1);
    pad_word[0] = 8'hF0;
    pad_word[1] = NB'($urandom_range(0, 255));
    frame_check(113, 1);
    pad_word[0] = 8'h0F;
    pad_word[1] = NB'($urandom_range(0, 255));
    frame_check(151, 1);
    start = 1'b0;

    // abort the poll-triggered frame that starts at cycle 200
    for (int i = 0; i < 200 && cyc < 210; i++) @(negedge clk);
    check("mid_frame_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    reset_outputs_check("mid_rst");
    #10;
    release_reset(1'b0);
    repeat (60) @(negedge clk);
    #1;
    check("post_rst_latch", latch_cycles, 0);
    check("post_rst_idle", busy_low, 60);
    check("post_rst_valid", valid_cnt, 0);
    check("post_rst_buttons", buttons, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
